// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, 11-bit frame on device clock falls, ACK check, timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam int FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          data_s;
  logic          timeout;
  logic          bus_wait;
  logic [TW-1:0] tmr;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          data_oe_q;

  // Line levels idle high, so synchronizers and filter reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign data_s   = data_sync[1];
  assign bus_wait = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout  = bus_wait && (tmr == TW'(TIMEOUT_CYCLES)) && !fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_next = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (tmr == TW'(INHIBIT_CYCLES - 1)) state_next = RTS;
      end
      RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_next  = SEND;
      end
      SEND: begin
        if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end else begin
          ps2_data_oe = data_oe_q;
          if (fall && bit_cnt == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end else if (fall) begin
          if (data_s) begin
            tx_error   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_s) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One timer serves both the inhibit hold and the per-edge timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      if (state_next != state || (fall && bus_wait)) begin
        tmr <= '0;
      end else if (state != IDLE) begin
        tmr <= tmr + 1'b1;
      end
      case (state)
        IDLE: begin
          data_oe_q <= 1'b0;
          if (tx_valid) begin
            shift   <= tx_data;
            parity  <= ~^tx_data;
            bit_cnt <= '0;
          end
        end
        RTS: data_oe_q <= 1'b1;
        SEND: begin
          if (timeout) begin
            data_oe_q <= 1'b0;
          end else if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              data_oe_q <= ~shift[0];
              shift     <= {1'b0, shift[7:1]};
            end else if (bit_cnt == 4'd8) begin
              data_oe_q <= ~parity;
            end else begin
              data_oe_q <= 1'b0;
            end
          end
        end
        default: data_oe_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;

  localparam int INH = 2500;
  localparam int TMO = 3000;
  localparam int FLT = 4;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic       par;
    bit         chk_bits;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         inh_cnt = 0;
  int         rts_cnt = 0;
  bit         pend_ready = 0;
  logic [7:0] rx_byte;
  logic       rx_par, rx_stop, rx_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      inh_cnt <= 0;
      rts_cnt <= 0;
    end else begin
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
      if (ps2_clk_oe && ps2_data_oe)  rts_cnt <= rts_cnt + 1;
    end
  end

  // Monitor: pops the expected outcome whenever the DUT reports one.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (pend_ready) begin
      check("ready_after_pulse", tx_ready, 1);
      pend_ready = 0;
    end
    if (reset_n && (tx_done || tx_error)) begin
      pend_ready = 1;
      check("done_error_exclusive", tx_done & tx_error, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("outcome_is_error", tx_error, e.is_err);
        if (e.chk_bits) begin
          check("rx_start", rx_start, 0);
          check("rx_byte", rx_byte, e.data);
          check("rx_parity", rx_par, e.par);
          check("rx_stop", rx_stop, 1);
        end
      end
    end
  end

  task automatic dev_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic device_frame(input bit ack, input bit glitch, input int abort_after);
    int t;
    logic [9:0] bits;
    bits = '0;
    t = 0;
    while (ps2_clk_in !== 1'b0 && t < 50) begin dev_wait(1); t++; end
    if (t >= 50) begin check("clock_inhibit_seen", 0, 1); return; end
    t = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < INH + 50) begin dev_wait(1); t++; end
    if (t >= INH + 50) begin check("rts_seen", 0, 1); return; end
    rx_start = ps2_data_in;
    dev_wait(H);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (abort_after == i + 1) begin
        dev_wait(H / 2);
        check("abort_data_oe_before", ps2_data_oe, 1);
        reset_n = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_ready", tx_ready, 1);
        check("abort_busy", busy, 0);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        dev_wait(3);
        reset_n = 1'b1;
        dev_wait(2);
        return;
      end
      dev_wait(H);
      bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      dev_wait(H);
      if (glitch && i == 2) begin
        dev_clk_low = 1'b1; dev_wait(1);
        dev_clk_low = 1'b0; dev_wait(8);
        dev_clk_low = 1'b1; dev_wait(3);
        dev_clk_low = 1'b0;
        tx_data = 8'h3C; tx_valid = 1'b1; dev_wait(1);
        tx_valid = 1'b0;
        dev_wait(H);
      end
    end
    rx_byte = bits[7:0];
    rx_par  = bits[8];
    rx_stop = bits[9];
    dev_wait(H / 2);
    if (ack) dev_data_low = 1'b1;
    dev_wait(H / 2);
    dev_clk_low = 1'b1;
    dev_wait(H);
    dev_clk_low = 1'b0;
    dev_wait(H / 2);
    dev_data_low = 1'b0;
    dev_wait(H);
  endtask

  task automatic send(input logic [7:0] d, input logic par, input bit ack, input bit glitch, input int abort_after);
    exp_t e;
    int t;
    if (abort_after == 0) begin
      e.is_err = !ack; e.data = d; e.par = par; e.chk_bits = 1;
      exp_q.push_back(e);
    end
    tx_data = d; tx_valid = 1'b1;
    dev_wait(1);
    tx_valid = 1'b0;
    tx_data = ~d;
    check("ready_low_after_accept", tx_ready, 0);
    check("busy_after_accept", busy, 1);
    device_frame(ack, glitch, abort_after);
    t = 0;
    while (tx_ready !== 1'b1 && t < 500) begin dev_wait(1); t++; end
    check("ready_returns", tx_ready, 1);
    if (abort_after == 0) begin
      check("inhibit_cycles", inh_cnt, INH);
      check("rts_cycles", rts_cnt, 1);
    end
    dev_wait(3);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic timeout_test();
    exp_t e;
    int t, t0;
    e.is_err = 1; e.data = 8'h00; e.par = 1'b0; e.chk_bits = 0;
    exp_q.push_back(e);
    tx_data = 8'hF4; tx_valid = 1'b1;
    dev_wait(1);
    tx_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (ps2_clk_oe !== 1'b0 && t < INH + 50);
    t0 = cyc;
    t = 0;
    do begin @(negedge clk); t++; end while (tx_error !== 1'b1 && t < TMO + 50);
    check("timeout_latency", cyc - t0, TMO);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("timeout_ready_next", tx_ready, 1);
    check("timeout_data_oe_next", ps2_data_oe, 0);
    dev_wait(3);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_done", tx_done, 0);
    check("reset_error", tx_error, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    dev_wait(2);

    //   data   parity ack glitch abort
    send(8'hF4, 1'b0, 1,  0,     0);
    send(8'hFF, 1'b1, 1,  0,     0);
    send(8'h00, 1'b1, 1,  0,     0);
    send(8'h5A, 1'b1, 0,  0,     0);
    timeout_test();
    send(8'hA5, 1'b1, 1,  1,     0);
    send(8'h00, 1'b1, 1,  0,     5);
    send(8'hF4, 1'b0, 1,  0,     0);

    dev_wait(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
